// File: rtl/len5_pkg.sv
// Shared frontend definitions: datapath width and the RAS controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package len5_pkg;

  localparam int XLEN = 32;

  // IDLE accepts requests, SWAP issues the deferred push of a pop+push,
  // DRAIN unwinds the stack one pop per cycle after a flush.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    DRAIN = 2'd2
  } ras_ctrl_state_t;

endpackage

// File: rtl/updown_counter.sv
// Up/down counter with enable and synchronous clear; saturation is the caller's job.
// Latency: count updates on the clock edge after en_i is seen.
// Backpressure: none; counts whenever en_i is high.
// Ports: clk_i/rst_i (async, active-high), en_i, up_i (1 = +1, 0 = -1), clr_i, cnt_o.
module updown_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer: arbitrates fetch/branch-unit push/pop requests,
// tracks occupancy, splits swaps into pop then push, unwinds the stack on flush.
// Latency: RAS push/pop/addr are combinational (0 cycles); a swap takes 2 cycles.
// Backpressure: branch unit has fixed priority; both readys drop outside IDLE or on flush.
// Ports: clk_i, rst_n_i (async, active-high despite the name), flush_i,
//   fe_*/bu_* request channels, ras_push_o/ras_pop_o/ras_addr_o to storage,
//   ras_valid_o, occ_o, busy_o status.
module ras_ctrl
  import len5_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           flush_i,
  input  logic                           fe_valid_i,
  output logic                           fe_ready_o,
  input  logic                           fe_push_i,
  input  logic                           fe_pop_i,
  input  logic [XLEN-1:0]                fe_addr_i,
  input  logic                           bu_valid_i,
  output logic                           bu_ready_o,
  input  logic                           bu_push_i,
  input  logic                           bu_pop_i,
  input  logic [XLEN-1:0]                bu_addr_i,
  output logic                           ras_push_o,
  output logic                           ras_pop_o,
  output logic [XLEN-1:0]                ras_addr_o,
  output logic                           ras_valid_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] occ_o,
  output logic                           busy_o
);

  localparam int OW = $clog2(RAS_DEPTH + 1);
  localparam logic [OW-1:0] OCC_MAX = OW'(RAS_DEPTH);

  ras_ctrl_state_t state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic [OW-1:0]   occ;
  logic            occ_nz;
  logic            occ_full;
  logic            cnt_en;
  logic            cnt_up;

  // Winning request: the branch unit whenever it is valid, else fetch.
  logic            req_valid;
  logic            req_push;
  logic            req_pop;
  logic [XLEN-1:0] req_addr;

  assign occ_nz    = (occ != '0);
  assign occ_full  = (occ == OCC_MAX);
  assign req_valid = bu_valid_i | fe_valid_i;
  assign req_push  = bu_valid_i ? bu_push_i : fe_push_i;
  assign req_pop   = bu_valid_i ? bu_pop_i  : fe_pop_i;
  assign req_addr  = bu_valid_i ? bu_addr_i : fe_addr_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fe_ready_o = 1'b0;
    bu_ready_o = 1'b0;
    ras_push_o = 1'b0;
    ras_pop_o  = 1'b0;
    ras_addr_o = '0;
    cnt_en     = 1'b0;
    cnt_up     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = occ_nz ? DRAIN : IDLE;
        end else begin
          bu_ready_o = 1'b1;
          fe_ready_o = ~bu_valid_i;
          if (req_valid) begin
            if (req_push && req_pop) begin
              // Pop now, push the latched address next cycle; push and pop never overlap.
              ras_pop_o = occ_nz;
              cnt_en    = occ_nz;
              addr_d    = req_addr;
              state_d   = SWAP;
            end else if (req_push) begin
              ras_push_o = 1'b1;
              ras_addr_o = req_addr;
              // Storage wraps when full; occupancy just saturates.
              cnt_en     = ~occ_full;
              cnt_up     = 1'b1;
            end else if (req_pop) begin
              ras_pop_o = occ_nz;
              cnt_en    = occ_nz;
            end
          end
        end
      end
      SWAP: begin
        if (flush_i) begin
          // The deferred push is dropped; unwind whatever is left.
          state_d = occ_nz ? DRAIN : IDLE;
        end else begin
          ras_push_o = 1'b1;
          ras_addr_o = addr_q;
          cnt_en     = ~occ_full;
          cnt_up     = 1'b1;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        ras_pop_o = occ_nz;
        cnt_en    = occ_nz;
        // Leave as the last entry is popped so busy lasts exactly occ cycles.
        if (occ <= OW'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  updown_counter #(
    .W (OW)
  ) u_occ_cnt (
    .clk_i (clk_i),
    .rst_i (rst_n_i),
    .en_i  (cnt_en),
    .up_i  (cnt_up),
    .clr_i (1'b0),
    .cnt_o (occ)
  );

  assign occ_o       = occ;
  assign ras_valid_o = occ_nz;
  assign busy_o      = (state_q != IDLE);

endmodule
